vga_rx_decoder: RTL

- Receiving end of the VGA link: samples HSYNC/VSYNC/RGB as driven by the VGA output path and recovers pixel coordinates, pixel-valid and frame timing.
- Checks line length and lines-per-frame against the 800x600@60 timing (40 MHz pixel clock) and runs a lock state machine.
- Used as an on-chip loopback checker and as the capture front end for a future frame-grab or CRC block.

---
 rtl/vga_rx_decoder_if.sv | 27 ++
 rtl/vga_rx_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder_if.sv
// Received VGA pins and the decoded pixel/timing outputs of the receive decoder.
// The decoder uses the slave side; the upstream source and any consumer use master.
interface vga_rx_decoder_if;
  logic       HSYNC_Sig;
  logic       VSYNC_Sig;
  logic [3:0] Red_Sig;
  logic [3:0] Green_Sig;
  logic [3:0] Blue_Sig;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [11:0] pix_rgb;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic       err_h;
  logic       err_v;

  modport master (
    output HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig,
    input  pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_h, err_v
  );

  modport slave (
    input  HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig,
    output pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_h, err_v
  );
endinterface

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: recovers pixel coordinates and frame timing from HSYNC/VSYNC/RGB,
// checks line and frame length against the nominal timing and tracks lock.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SEARCH | no frame seen yet or timing error; checks suppressed
// ST_ALIGN  | one frame start seen; waiting for a clean second one
// ST_LOCKED | timing verified; pixels are reported as valid
module vga_rx_decoder #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int SYNC_POL = 1
) (
  input  logic            vga_clk,
  input  logic            RST,
  vga_rx_decoder_if.slave vga
);

  localparam logic        SYNC_ACT = (SYNC_POL != 0);
  localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [10:0] H_LO     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_HI     = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0]  V_LO     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_HI     = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_MAX    = 11'h7FF;
  localparam logic [9:0]  V_MAX    = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hs1_q, hs2_q, vs1_q, vs2_q;
  logic [11:0] rgb1_q;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        pend_q, pend_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        err_h_q, err_h_d, err_v_q, err_v_d;

  logic h_edge, v_edge, frame, h_sat, chk, in_win;

  always_comb begin
    h_edge = (hs1_q == SYNC_ACT) && (hs2_q != SYNC_ACT);
    v_edge = (vs1_q == SYNC_ACT) && (vs2_q != SYNC_ACT);
    // a vsync edge coincident with an hsync edge belongs to that line
    frame  = h_edge && (pend_q || v_edge);
    pend_d = frame ? 1'b0 : (pend_q || v_edge);

    h_sat   = !h_edge && (h_cnt_q == H_MAX - 11'd1);
    h_cnt_d = h_edge ? 11'd0 : ((h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + 11'd1);

    v_cnt_d = v_cnt_q;
    if (frame)       v_cnt_d = 10'd0;
    else if (h_edge) v_cnt_d = (v_cnt_q == V_MAX) ? v_cnt_q : v_cnt_q + 10'd1;

    chk     = (state_q != ST_SEARCH);
    err_h_d = chk && ((h_edge && (h_cnt_q != H_LAST)) || h_sat);
    err_v_d = chk && frame && (v_cnt_q != V_LAST);

    state_d = state_q;
    case (state_q)
      ST_SEARCH: if (frame) state_d = ST_ALIGN;
      ST_ALIGN: begin
        if (err_h_d || err_v_d) state_d = ST_SEARCH;
        else if (frame)         state_d = ST_LOCKED;
      end
      ST_LOCKED: if (err_h_d || err_v_d) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase

    // window is evaluated on the counts that will belong to the pixel now in stage 1
    in_win = (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) && (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
    pix_valid_d   = in_win && (state_d == ST_LOCKED);
    pix_x_d       = pix_valid_d ? 10'(h_cnt_d - H_LO) : pix_x_q;
    pix_y_d       = pix_valid_d ? (v_cnt_d - V_LO) : pix_y_q;
    pix_rgb_d     = pix_valid_d ? rgb1_q : pix_rgb_q;
    frame_start_d = frame;
    locked_d      = (state_d == ST_LOCKED);
  end

  always_ff @(posedge vga_clk) begin
    if (RST) begin
      state_q       <= ST_SEARCH;
      hs1_q         <= !SYNC_ACT;
      hs2_q         <= !SYNC_ACT;
      vs1_q         <= !SYNC_ACT;
      vs2_q         <= !SYNC_ACT;
      rgb1_q        <= 12'd0;
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 10'd0;
      pend_q        <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      pix_rgb_q     <= 12'd0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs1_q         <= vga.HSYNC_Sig;
      hs2_q         <= hs1_q;
      vs1_q         <= vga.VSYNC_Sig;
      vs2_q         <= vs1_q;
      rgb1_q        <= {vga.Red_Sig, vga.Green_Sig, vga.Blue_Sig};
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pend_q        <= pend_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
    end
  end

  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.pix_rgb     = pix_rgb_q;
  assign vga.pix_valid   = pix_valid_q;
  assign vga.frame_start = frame_start_q;
  assign vga.locked      = locked_q;
  assign vga.err_h       = err_h_q;
  assign vga.err_v       = err_v_q;

endmodule
